// File: rtl/piso_shift32.sv
// piso_shift32: parallel-in, serial-out shift register with a valid/ready load
// port, a serial valid qualifier and a frame-start marker.
// Optional feature: define PISO_PARITY_EN to append one even-parity bit
// (XOR-reduce of the accepted word) after the last data bit of every frame.
module piso_shift32 #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned        CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   sreg;
    logic [CNT_W-1:0]   cnt;
`ifdef PISO_PARITY_EN
    logic               parity_q;
`endif

    logic               at_last;
    logic               accept;
    logic               head_bit;
    logic [WIDTH-1:0]   sreg_shifted;

    // Handshake: ready when idle or on the final cycle of a frame; held low in reset.
    always_comb begin
        at_last    = (state == SHIFT) && (cnt == LAST_CNT);
        load_ready = reset_n && ((state == IDLE) || at_last);
        accept     = load_valid && load_ready;
    end

    // Head-bit selection and shift-toward-head with zero fill.
    always_comb begin
        if (MSB_FIRST) begin
            head_bit     = sreg[WIDTH-1];
            sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
        end else begin
            head_bit     = sreg[0];
            sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
        end
    end

    // Serial outputs, decoded purely from registered state.
    always_comb begin
        sout_valid  = (state == SHIFT);
        busy        = sout_valid;
        frame_start = sout_valid && (cnt == '0);
`ifdef PISO_PARITY_EN
        if (cnt == CNT_W'(WIDTH)) begin
            sout = sout_valid && parity_q;
        end else begin
            sout = sout_valid && head_bit;
        end
`else
        sout = sout_valid && head_bit;
`endif
    end

    // Frame FSM: load on accept, shift one bit per edge, return to idle after the last bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            if (accept) begin
                state <= SHIFT;
                sreg  <= d;
                cnt   <= '0;
`ifdef PISO_PARITY_EN
                parity_q <= ^d;
`endif
            end else if (state == SHIFT) begin
                if (at_last) begin
                    state <= IDLE;
                    sreg  <= '0;
                    cnt   <= '0;
                end else begin
                    sreg <= sreg_shifted;
                    cnt  <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_piso_shift32.sv
// Bench for piso_shift32: one MSB-first and one LSB-first instance share stimulus.
// A queue-based model of the expected serial stream is checked every cycle;
// a vector table and hand-written sequences cover the documented scenarios.
module tb_piso_shift32;

    localparam int unsigned W = 32;
`ifdef PISO_PARITY_EN
    localparam int unsigned FRAME = W + 1;
`else
    localparam int unsigned FRAME = W;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [W-1:0]  d = '0;
    logic          load_valid = 1'b0;

    logic load_ready_m, sout_m, sout_valid_m, frame_start_m, busy_m;
    logic load_ready_l, sout_l, sout_valid_l, frame_start_l, busy_l;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // expected remaining bits of the frame on the wire, head first
    logic q_m[$];
    logic q_l[$];

    // serial capture (valid cycles only)
    logic cap_m[$];
    logic cap_l[$];
    logic cap_fs_m[$];
    logic cap_fs_l[$];
    int   cap_cyc[$];

    piso_shift32 #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset_n(reset_n), .d(d), .load_valid(load_valid),
        .load_ready(load_ready_m), .sout(sout_m), .sout_valid(sout_valid_m),
        .frame_start(frame_start_m), .busy(busy_m)
    );

    piso_shift32 #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset_n(reset_n), .d(d), .load_valid(load_valid),
        .load_ready(load_ready_l), .sout(sout_l), .sout_valid(sout_valid_l),
        .frame_start(frame_start_l), .busy(busy_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the wire carries a frame as a list of bits; each edge consumes one,
    // and an accepted word replaces the (empty or last-bit) list with its bits.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_m.delete();
            q_l.delete();
        end else begin
            logic acc;
            acc = load_valid && (q_m.size() <= 1);
            if (q_m.size() > 0) void'(q_m.pop_front());
            if (q_l.size() > 0) void'(q_l.pop_front());
            if (acc) begin
                q_m.delete();
                q_l.delete();
                for (int i = W - 1; i >= 0; i--) q_m.push_back(d[i]);
                for (int i = 0; i < W; i++)      q_l.push_back(d[i]);
`ifdef PISO_PARITY_EN
                q_m.push_back(^d);
                q_l.push_back(^d);
`endif
            end
        end
    end

    // Per-cycle comparison against the model, plus serial capture.
    always @(negedge clk) begin
        logic ev_m, ev_l, eb_m, eb_l, ef_m, ef_l, er;
        cyc++;
        ev_m = q_m.size() > 0;
        ev_l = q_l.size() > 0;
        eb_m = ev_m ? q_m[0] : 1'b0;
        eb_l = ev_l ? q_l[0] : 1'b0;
        ef_m = ev_m && (q_m.size() == FRAME);
        ef_l = ev_l && (q_l.size() == FRAME);
        er   = reset_n && (q_m.size() <= 1);
        chk("msb_sout",        64'(sout_m),        64'(eb_m));
        chk("msb_sout_valid",  64'(sout_valid_m),  64'(ev_m));
        chk("msb_busy",        64'(busy_m),        64'(ev_m));
        chk("msb_frame_start", 64'(frame_start_m), 64'(ef_m));
        chk("msb_load_ready",  64'(load_ready_m),  64'(er));
        chk("lsb_sout",        64'(sout_l),        64'(eb_l));
        chk("lsb_sout_valid",  64'(sout_valid_l),  64'(ev_l));
        chk("lsb_busy",        64'(busy_l),        64'(ev_l));
        chk("lsb_frame_start", 64'(frame_start_l), 64'(ef_l));
        chk("lsb_load_ready",  64'(load_ready_l),  64'(er));
        if (sout_valid_m) begin
            cap_m.push_back(sout_m);
            cap_fs_m.push_back(frame_start_m);
            cap_cyc.push_back(cyc);
        end
        if (sout_valid_l) begin
            cap_l.push_back(sout_l);
            cap_fs_l.push_back(frame_start_l);
        end
    end

    task automatic clear_cap();
        cap_m.delete(); cap_l.delete(); cap_fs_m.delete(); cap_fs_l.delete(); cap_cyc.delete();
    endtask

    // Present a word (called just after a negedge) and hold it until accepted.
    task automatic send(input logic [W-1:0] w, input bit drop);
        bit ok;
        ok = 1'b0;
        d = w;
        load_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (load_ready_m) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
        end
        if (drop) load_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!sout_valid_m && !sout_valid_l) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL idle_timeout: got busy expected idle within 300 cycles");
        end
    endtask

    function automatic logic [W-1:0] rebuild_m(input int base);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[W-1-i] = cap_m[base + i];
        return r;
    endfunction

    function automatic logic [W-1:0] rebuild_l(input int base);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = cap_l[base + i];
        return r;
    endfunction

    typedef struct {
        logic [W-1:0] word;
        logic         first_msb;
        logic         first_lsb;
        logic         parity;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [W-1:0] w1, w2;
        vecs[0] = '{32'h321a289b, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{32'hd1982735, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{32'h00000001, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{32'h18494487, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{32'h80000000, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{32'h00000003, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{32'hffffffff, 1'b1, 1'b1, 1'b0};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_load_ready", 64'(load_ready_m), 64'd0);
        chk("rst_sout_valid", 64'(sout_valid_m), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("post_rst_load_ready", 64'(load_ready_m), 64'd1);
        @(negedge clk);

        // table: one isolated frame per vector
        for (int k = 0; k < 7; k++) begin
            clear_cap();
            send(vecs[k].word, 1'b1);
            wait_idle();
            chk("tbl_len_m", 64'(cap_m.size()), 64'(FRAME));
            chk("tbl_len_l", 64'(cap_l.size()), 64'(FRAME));
            if (cap_m.size() == FRAME && cap_l.size() == FRAME) begin
                chk("tbl_first_m", 64'(cap_m[0]), 64'(vecs[k].first_msb));
                chk("tbl_first_l", 64'(cap_l[0]), 64'(vecs[k].first_lsb));
                chk("tbl_word_m",  64'(rebuild_m(0)), 64'(vecs[k].word));
                chk("tbl_word_l",  64'(rebuild_l(0)), 64'(vecs[k].word));
                chk("tbl_fs_m",    64'(cap_fs_m[0]), 64'd1);
                chk("tbl_fs_l",    64'(cap_fs_l[0]), 64'd1);
                chk("tbl_fs_once", 64'(cap_fs_m.sum() with (int'(item))), 64'd1);
`ifdef PISO_PARITY_EN
                chk("tbl_parity_m", 64'(cap_m[W]), 64'(vecs[k].parity));
                chk("tbl_parity_l", 64'(cap_l[W]), 64'(vecs[k].parity));
`endif
            end
            chk("tbl_idle_sout", 64'(sout_m), 64'd0);
        end

        // back-to-back frames with load_valid held
        w1 = 32'h321a289b;
        w2 = 32'hd1982735;
        clear_cap();
        send(w1, 1'b0);
        send(w2, 1'b1);
        wait_idle();
        chk("b2b_len", 64'(cap_m.size()), 64'(2 * FRAME));
        if (cap_m.size() == 2 * FRAME) begin
            chk("b2b_contig", 64'(cap_cyc[2*FRAME-1] - cap_cyc[0] + 1), 64'(2 * FRAME));
            chk("b2b_fs_1",   64'(cap_fs_m[0]), 64'd1);
            chk("b2b_fs_2",   64'(cap_fs_m[FRAME]), 64'd1);
            chk("b2b_fs_cnt", 64'(cap_fs_m.sum() with (int'(item))), 64'd2);
            chk("b2b_w1",     64'(rebuild_m(0)), 64'(w1));
            chk("b2b_w2",     64'(rebuild_m(FRAME)), 64'(w2));
        end

        // load_valid pulse mid-frame is ignored
        clear_cap();
        send(w1, 1'b1);
        repeat (10) @(negedge clk);
        d = 32'h18494487;
        load_valid = 1'b1;
        #1;
        chk("mid_load_ready", 64'(load_ready_m), 64'd0);
        @(negedge clk);
        load_valid = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        chk("mid_len", 64'(cap_m.size()), 64'(FRAME));
        if (cap_m.size() == FRAME) chk("mid_word", 64'(rebuild_m(0)), 64'(w1));

        // asynchronous reset at bit 16, then a clean frame
        clear_cap();
        send(w1, 1'b1);
        repeat (16) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_sout",        64'(sout_m),        64'd0);
        chk("arst_sout_valid",  64'(sout_valid_m),  64'd0);
        chk("arst_busy",        64'(busy_m),        64'd0);
        chk("arst_frame_start", 64'(frame_start_m), 64'd0);
        chk("arst_load_ready",  64'(load_ready_m),  64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("arst_rel_ready", 64'(load_ready_m), 64'd1);
        clear_cap();
        send(w2, 1'b1);
        wait_idle();
        chk("arst_len", 64'(cap_m.size()), 64'(FRAME));
        if (cap_m.size() == FRAME) begin
            chk("arst_word_m", 64'(rebuild_m(0)), 64'(w2));
            chk("arst_word_l", 64'(rebuild_l(0)), 64'(w2));
        end

        // randomized traffic with idle gaps and back-to-back runs
        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            if (gap > 0) begin
                load_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            send(W'($urandom), 1'($urandom_range(0, 1)));
        end
        load_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
